// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU with iterative shift-add multiplier
//
// Purpose: accepts one operation per valid/ready handshake. Single-cycle ops
// (add/sub/logic/shift) complete on the accepting edge. MULU/MULS run a
// WIDTH-step shift-add on operand magnitudes. Results and flags are held
// until the consumer takes them.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   request handshake (ready only while idle)
//   op, x, y, cin       opcode, operands (y doubles as shift amount), carry-in
//   out_valid/out_ready result handshake (valid only while done)
//   res_lo, res_hi      result / product halves (res_hi = 0 for non-multiply)
//   flag_c/z/n/v        carry/borrow, zero, negative, overflow
//   err                 illegal opcode
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v,
   output logic             err
);

   localparam int M = WIDTH - 1;
   localparam logic [WIDTH-1:0] W_VAL    = WIDTH'(WIDTH);
   localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_ADC  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_NOT  = 4'd6;
   localparam logic [3:0] OP_SHL  = 4'd7;
   localparam logic [3:0] OP_SHR  = 4'd8;
   localparam logic [3:0] OP_SAR  = 4'd9;
   localparam logic [3:0] OP_MULU = 4'd10;
   localparam logic [3:0] OP_MULS = 4'd11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic               muls_q, muls_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   res_lo_q, res_lo_d;
   logic [WIDTH-1:0]   res_hi_q, res_hi_d;
   logic               c_q, c_d;
   logic               z_q, z_d;
   logic               n_q, n_d;
   logic               v_q, v_d;
   logic               err_q, err_d;

   // Single-cycle datapath
   logic [WIDTH:0]     add_sum;
   logic [WIDTH-1:0]   sub_dif;
   logic [WIDTH:0]     shl_ext;
   logic [WIDTH:0]     shr_ext;
   logic [WIDTH:0]     sar_ext;
   logic [SHW-1:0]     sh_amt;
   logic               sh_lt_w;
   logic               sh_eq_w;
   logic [WIDTH-1:0]   sc_res;
   logic               sc_c;
   logic               sc_v;
   logic               sc_err;

   // Multiplier helpers
   logic               is_mul_op;
   logic               is_muls_op;
   logic [WIDTH-1:0]   mag_x;
   logic [WIDTH-1:0]   mag_y;
   logic [2*WIDTH-1:0] step_sum;
   logic [2*WIDTH-1:0] prod;

   assign sh_amt  = y[SHW-1:0];
   assign sh_lt_w = (y < W_VAL);
   assign sh_eq_w = (y == W_VAL);

   // Shifts carry one guard bit so the last bit shifted out falls into it;
   // a zero shift leaves the guard bit at 0, which is the required carry.
   always_comb begin
      add_sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, (op == OP_ADC) & cin};
      sub_dif = x - y;
      shl_ext = {1'b0, x} << sh_amt;
      shr_ext = {x, 1'b0} >> sh_amt;
      sar_ext = $signed({x, 1'b0}) >>> sh_amt;
      sc_res  = '0;
      sc_c    = 1'b0;
      sc_v    = 1'b0;
      sc_err  = 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            sc_res = add_sum[M:0];
            sc_c   = add_sum[WIDTH];
            sc_v   = (x[M] == y[M]) && (add_sum[M] != x[M]);
         end
         OP_SUB: begin
            sc_res = sub_dif;
            sc_c   = (x < y);
            sc_v   = (x[M] != y[M]) && (sub_dif[M] != x[M]);
         end
         OP_AND: sc_res = x & y;
         OP_OR:  sc_res = x | y;
         OP_XOR: sc_res = x ^ y;
         OP_NOT: sc_res = ~x;
         OP_SHL: begin
            if (sh_lt_w) begin
               sc_res = shl_ext[M:0];
               sc_c   = shl_ext[WIDTH];
            end else if (sh_eq_w) begin
               sc_c = x[0];
            end
         end
         OP_SHR: begin
            if (sh_lt_w) begin
               sc_res = shr_ext[WIDTH:1];
               sc_c   = shr_ext[0];
            end else if (sh_eq_w) begin
               sc_c = x[M];
            end
         end
         OP_SAR: begin
            if (sh_lt_w) begin
               sc_res = sar_ext[WIDTH:1];
               sc_c   = sar_ext[0];
            end else begin
               sc_res = {WIDTH{x[M]}};
               sc_c   = sh_eq_w & x[M];
            end
         end
         OP_MULU, OP_MULS: sc_res = '0;
         default: sc_err = 1'b1;
      endcase
   end

   assign is_muls_op = (op == OP_MULS);
   assign is_mul_op  = (op == OP_MULU) || is_muls_op;
   // Two's-complement negation of the most-negative value yields 2^(W-1),
   // which is exactly its magnitude when read as unsigned.
   assign mag_x = (is_muls_op && x[M]) ? -x : x;
   assign mag_y = (is_muls_op && y[M]) ? -y : y;

   assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign prod     = neg_q ? -step_sum : step_sum;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      muls_d   = muls_q;
      neg_d    = neg_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      c_d      = c_q;
      z_d      = z_q;
      n_d      = n_q;
      v_d      = v_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (is_mul_op) begin
                  state_d  = S_MUL;
                  cnt_d    = '0;
                  acc_d    = '0;
                  mcand_d  = {{WIDTH{1'b0}}, mag_x};
                  mplier_d = mag_y;
                  muls_d   = is_muls_op;
                  neg_d    = is_muls_op & (x[M] ^ y[M]);
               end else begin
                  state_d  = S_DONE;
                  res_lo_d = sc_res;
                  res_hi_d = '0;
                  c_d      = sc_c;
                  z_d      = ~sc_err & (sc_res == '0);
                  n_d      = sc_res[M];
                  v_d      = sc_v;
                  err_d    = sc_err;
               end
            end
         end
         S_MUL: begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHW'(1);
            // Last step folds straight into the result and applies the sign.
            if (cnt_q == CNT_LAST) begin
               state_d  = S_DONE;
               res_lo_d = prod[M:0];
               res_hi_d = prod[2*WIDTH-1:WIDTH];
               c_d      = 1'b0;
               z_d      = (prod == '0);
               n_d      = prod[2*WIDTH-1];
               v_d      = muls_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[M]}})
                                 : (prod[2*WIDTH-1:WIDTH] != '0);
               err_d    = 1'b0;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         muls_q   <= 1'b0;
         neg_q    <= 1'b0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         c_q      <= 1'b0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         v_q      <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         muls_q   <= muls_d;
         neg_q    <= neg_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         c_q      <= c_d;
         z_q      <= z_d;
         n_q      <= n_d;
         v_q      <= v_d;
         err_q    <= err_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign res_lo    = res_lo_q;
   assign res_hi    = res_hi_q;
   assign flag_c    = c_q;
   assign flag_z    = z_q;
   assign flag_n    = n_q;
   assign flag_v    = v_q;
   assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH=32 and WIDTH=8)
module tb_alu_seq;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      logic        cin;
      logic [31:0] lo;
      logic [31:0] hi;
      logic [4:0]  fl;  // {c, z, n, v, err}
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic [4:0]  fl;
      int          lat;
      bit          busy_ready;
   } res_t;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -SMAX - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, cin, out_valid, out_ready;
   logic [3:0]  op;
   logic [31:0] x, y, res_lo, res_hi;
   logic        flag_c, flag_z, flag_n, flag_v, err;

   logic        b_in_valid, b_in_ready, b_cin, b_out_valid, b_out_ready;
   logic [3:0]  b_op;
   logic [7:0]  b_x, b_y, b_res_lo, b_res_hi;
   logic        b_c, b_z, b_n, b_v, b_err;

   int n_tests = 0;
   int n_fail  = 0;
   vec_t vecs[$];

   alu_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .x(x), .y(y), .cin(cin), .out_valid(out_valid),
      .out_ready(out_ready), .res_lo(res_lo), .res_hi(res_hi),
      .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
      .err(err)
   );

   alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .op(b_op), .x(b_x), .y(b_y), .cin(b_cin), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .res_lo(b_res_lo), .res_hi(b_res_hi),
      .flag_c(b_c), .flag_z(b_z), .flag_n(b_n), .flag_v(b_v), .err(b_err)
   );

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference model: plain wide arithmetic on the operation's meaning.
   function automatic res_t model(input logic [3:0] o, input logic [31:0] a,
                                  input logic [31:0] b, input logic ci);
      res_t        r;
      longint      sa, sb, s;
      logic [63:0] u, p;
      logic        c, v, e, is_mul;
      logic [31:0] lo, hi;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      c = 1'b0; v = 1'b0; e = 1'b0; is_mul = 1'b0;
      lo = '0; hi = '0; p = '0;
      case (o)
         4'd0, 4'd1: begin
            u  = {32'b0, a} + {32'b0, b} + ((o == 4'd1 && ci) ? 64'd1 : 64'd0);
            lo = u[31:0];
            c  = u[32];
            s  = sa + sb + ((o == 4'd1 && ci) ? 64'sd1 : 64'sd0);
            v  = (s > SMAX) || (s < SMIN);
         end
         4'd2: begin
            lo = a - b;
            c  = (a < b);
            s  = sa - sb;
            v  = (s > SMAX) || (s < SMIN);
         end
         4'd3: lo = a & b;
         4'd4: lo = a | b;
         4'd5: lo = a ^ b;
         4'd6: lo = ~a;
         4'd7: begin
            lo = (b >= 32) ? 32'd0 : (a << b);
            if (b >= 1 && b <= 32) begin
               u = {32'b0, a} >> (32 - int'(b));
               c = u[0];
            end
         end
         4'd8: begin
            lo = (b >= 32) ? 32'd0 : (a >> b);
            if (b >= 1 && b <= 32) begin
               u = {32'b0, a} >> (int'(b) - 1);
               c = u[0];
            end
         end
         4'd9: begin
            lo = (b >= 32) ? {32{a[31]}} : 32'(sa >>> b);
            if (b >= 1 && b <= 32) begin
               s = sa >>> (int'(b) - 1);
               c = s[0];
            end
         end
         4'd10: begin
            is_mul = 1'b1;
            p  = {32'b0, a} * {32'b0, b};
            v  = (p > 64'hFFFF_FFFF);
         end
         4'd11: begin
            is_mul = 1'b1;
            s  = sa * sb;
            p  = s;
            v  = (s > SMAX) || (s < SMIN);
         end
         default: e = 1'b1;
      endcase
      if (is_mul) begin
         lo    = p[31:0];
         hi    = p[63:32];
         r.fl  = {1'b0, p == 64'd0, p[63], v, 1'b0};
         r.lat = 33;
      end else begin
         r.fl  = {c, !e && lo == 32'd0, lo[31], v, e};
         r.lat = 1;
      end
      r.lo = lo;
      r.hi = hi;
      r.busy_ready = 1'b0;
      return r;
   endfunction

   // One full transaction on the 32-bit instance; operands are scrambled and
   // a spurious request is held up while busy to show they were latched.
   task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, output res_t r);
      int lat;
      bit rdy;
      @(negedge clk);
      op = o; x = a; y = b; cin = ci; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      op = 4'd0; x = ~a; y = ~b; cin = ~ci;
      lat = 1;
      rdy = 1'b0;
      while (!out_valid && lat < 200) begin
         if (in_ready) rdy = 1'b1;
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      r.lo = res_lo;
      r.hi = res_hi;
      r.fl = {flag_c, flag_z, flag_n, flag_v, err};
      r.lat = lat;
      r.busy_ready = rdy;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic cmp_res(input string tag, input res_t g, input res_t e);
      chk({tag, " result"}, {g.hi, g.lo}, {e.hi, e.lo});
      chk({tag, " flags"}, g.fl, e.fl);
      chk({tag, " latency"}, g.lat, e.lat);
      if (e.lat > 1) chk({tag, " in_ready while busy"}, g.busy_ready, 1'b0);
   endtask

   task automatic add_vec(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic [31:0] lo, input logic [31:0] hi,
                          input logic [4:0] fl, input int lat);
      vec_t v;
      v.op = o; v.x = a; v.y = b; v.cin = ci;
      v.lo = lo; v.hi = hi; v.fl = fl; v.lat = lat;
      vecs.push_back(v);
   endtask

   task automatic run8(input string tag, input logic [3:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] ep, input logic [4:0] efl,
                       input int elat);
      int lat;
      @(negedge clk);
      b_op = o; b_x = a; b_y = b; b_in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b_in_valid = 1'b0;
      lat = 1;
      while (!b_out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " result"}, {b_res_hi, b_res_lo}, ep);
      chk({tag, " flags"}, {b_c, b_z, b_n, b_v, b_err}, efl);
      chk({tag, " latency"}, lat, elat);
      b_out_ready = 1'b1;
      @(negedge clk);
      b_out_ready = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'hFFFF_FFFF;
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      res_t g, e;
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      logic        rc;

      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; op = '0; x = '0; y = '0; cin = 1'b0;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_op = '0; b_x = '0; b_y = '0; b_cin = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset w32", {in_ready, out_valid, res_hi, res_lo, flag_c, flag_z, flag_n, flag_v, err},
          {1'b1, 1'b0, 64'd0, 5'd0});
      chk("reset w8", {b_in_ready, b_out_valid, b_res_hi, b_res_lo, b_c, b_z, b_n, b_v, b_err},
          {1'b1, 1'b0, 16'd0, 5'd0});
      rst = 1'b0;

      //       op     x             y             cin  lo            hi            czNVe     lat
      add_vec(4'd0,  32'h2,        32'h6,        0, 32'h8,        32'h0,        5'b00000, 1);
      add_vec(4'd1,  32'h2,        32'h6,        1, 32'h9,        32'h0,        5'b00000, 1);
      add_vec(4'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 32'h0,        5'b10100, 1);
      add_vec(4'd1,  32'hFFFFFFFF, 32'h0,        1, 32'h0,        32'h0,        5'b11000, 1);
      add_vec(4'd2,  32'hA,        32'hFFFFFFEC, 0, 32'h1E,       32'h0,        5'b10000, 1);
      add_vec(4'd2,  32'h80000000, 32'h1,        0, 32'h7FFFFFFF, 32'h0,        5'b00010, 1);
      add_vec(4'd0,  32'h7FFFFFFF, 32'h1,        0, 32'h80000000, 32'h0,        5'b00110, 1);
      add_vec(4'd2,  32'h5,        32'h5,        0, 32'h0,        32'h0,        5'b01000, 1);
      add_vec(4'd3,  32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'h00F000F0, 32'h0,        5'b00000, 1);
      add_vec(4'd4,  32'h12340000, 32'h00005678, 0, 32'h12345678, 32'h0,        5'b00000, 1);
      add_vec(4'd5,  32'hFFFF0000, 32'hFF00FF00, 0, 32'h00FFFF00, 32'h0,        5'b00000, 1);
      add_vec(4'd6,  32'h0,        32'h1234,     0, 32'hFFFFFFFF, 32'h0,        5'b00100, 1);
      add_vec(4'd9,  32'h80000301, 32'd2,        0, 32'hE00000C0, 32'h0,        5'b00100, 1);
      add_vec(4'd8,  32'h80000301, 32'd2,        0, 32'h200000C0, 32'h0,        5'b00000, 1);
      add_vec(4'd7,  32'h80000301, 32'd2,        0, 32'h00000C04, 32'h0,        5'b00000, 1);
      add_vec(4'd7,  32'h80000301, 32'd40,       0, 32'h0,        32'h0,        5'b01000, 1);
      add_vec(4'd9,  32'h80000000, 32'd33,       0, 32'hFFFFFFFF, 32'h0,        5'b00100, 1);
      add_vec(4'd8,  32'h80000000, 32'd32,       0, 32'h0,        32'h0,        5'b11000, 1);
      add_vec(4'd7,  32'h00000001, 32'd32,       0, 32'h0,        32'h0,        5'b11000, 1);
      add_vec(4'd8,  32'h3,        32'd1,        0, 32'h1,        32'h0,        5'b10000, 1);
      add_vec(4'd10, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 32'h00000001, 32'h3FFFFFFF, 5'b00010, 33);
      add_vec(4'd11, 32'hFFFFFFFD, 32'h5,        0, 32'hFFFFFFF1, 32'hFFFFFFFF, 5'b00100, 33);
      add_vec(4'd11, 32'h80000000, 32'h80000000, 0, 32'h0,        32'h40000000, 5'b00010, 33);
      add_vec(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h1,        32'h0,        5'b00000, 33);
      add_vec(4'd10, 32'h0,        32'h12345678, 0, 32'h0,        32'h0,        5'b01000, 33);
      add_vec(4'd13, 32'h1234,     32'h5678,     1, 32'h0,        32'h0,        5'b00001, 1);
      add_vec(4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h0,        32'h0,        5'b00001, 1);

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].cin, g);
         e.lo = vecs[i].lo; e.hi = vecs[i].hi; e.fl = vecs[i].fl;
         e.lat = vecs[i].lat; e.busy_ready = 1'b0;
         cmp_res($sformatf("vec%0d op%0d", i, vecs[i].op), g, e);
      end

      // Backpressure: AND result held for 5 cycles while a new request waits.
      @(negedge clk);
      op = 4'd3; x = 32'hF0F0F0F0; y = 32'h0FF00FF0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      op = 4'd0; x = 32'd2; y = 32'd6; cin = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("hold cycle %0d", k),
             {out_valid, in_ready, res_hi, res_lo, flag_c, flag_z, flag_n, flag_v, err},
             {1'b1, 1'b0, 32'h0, 32'h00F000F0, 5'b00000});
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release no same-cycle accept", {out_valid, in_ready, res_lo}, {1'b1 ^ 1'b1, 1'b1, 32'h00F000F0});
      @(negedge clk);
      in_valid = 1'b0;
      chk("accept after release", {out_valid, res_lo, flag_c, flag_z, flag_n, flag_v, err},
          {1'b1, 32'h8, 5'b00000});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Reset mid-multiply (result register currently holds 8).
      @(negedge clk);
      op = 4'd10; x = 32'h7FFFFFFF; y = 32'h7FFFFFFF; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("mid-mul busy", {in_ready, out_valid}, 2'b00);
      #2 rst = 1'b1;
      #1;
      chk("async reset mid-mul",
          {in_ready, out_valid, res_hi, res_lo, flag_c, flag_z, flag_n, flag_v, err},
          {1'b1, 1'b0, 64'd0, 5'd0});
      @(negedge clk);
      rst = 1'b0;
      run_op(4'd0, 32'd100, 32'd23, 1'b0, g);
      cmp_res("after reset", g, model(4'd0, 32'd100, 32'd23, 1'b0));

      // WIDTH=8 instance
      run8("w8 mulu ff*ff", 4'd10, 8'hFF, 8'hFF, 16'hFE01, 5'b00110, 9);
      run8("w8 muls 80*80", 4'd11, 8'h80, 8'h80, 16'h4000, 5'b00010, 9);
      run8("w8 muls -1*1",  4'd11, 8'hFF, 8'h01, 16'hFFFF, 5'b00100, 9);
      run8("w8 add carry",  4'd0,  8'hF0, 8'h20, 16'h0010, 5'b10000, 1);
      run8("w8 sar by 8",   4'd9,  8'h81, 8'd8,  16'h00FF, 5'b10100, 1);
      run8("w8 shl by 9",   4'd7,  8'h81, 8'd9,  16'h0000, 5'b01000, 1);

      // Randomised ops against the reference model.
      for (int i = 0; i < 300; i++) begin
         ro = 4'($urandom_range(0, 15));
         ra = pick();
         rb = (ro >= 4'd7 && ro <= 4'd9 && $urandom_range(0, 1) == 1)
              ? 32'($urandom_range(0, 40)) : pick();
         rc = 1'($urandom_range(0, 1));
         run_op(ro, ra, rb, rc, g);
         cmp_res($sformatf("rand%0d op%0d x=%h y=%h", i, ro, ra, rb), g, model(ro, ra, rb, rc));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
